bcd_stopwatch_ctrl: RTL and testbench
=====================================

Name: bcd_stopwatch_ctrl

Overview:
- Controller that sequences a cascade of four decade (0–9) digit counters as a stopwatch: start, pause, resume, clear and lap capture.
- A programmable prescaler gates increments, so the count advances once every PRESCALE clocks while running.
- Sits above the counter datapath and drives display or readout logic through packed BCD outputs.

Parameters:
PRESCALE, 10, clocks per count increment while running; legal values >= 2.
PS_W, 8, prescaler counter width; must satisfy 2**PS_W >= PRESCALE.

Ports:
clk  input  1  clock; all state changes on posedge.
reset  input  1  synchronous, active-high reset.
start  input  1  level command: enter or resume RUN.
stop  input  1  level command: pause (RUN -> PAUSE).
clear  input  1  level command: zero the count and return to IDLE.
lap  input  1  capture current count into lap_val.
count  output  16  packed BCD {d3,d2,d1,d0}; d0 is the least significant digit.
lap_val  output  16  packed BCD snapshot of count.
lap_valid  output  1  one-cycle pulse on the cycle after a capture.
running  output  1  high when the state is RUN.
tick  output  1  one-cycle pulse on the edge where count increments.
overflow  output  1  one-cycle pulse on the 9999 -> 0000 wrap.

Behaviour:
- Reset (reset=1 at posedge):
  - state=IDLE, prescaler=0.
  - count=0000, lap_val=0000.
  - lap_valid=0, tick=0, overflow=0, running=0.
  - Reset overrides every command in the same cycle.
- FSM states: IDLE, RUN, PAUSE. Command priority within one cycle is clear > stop > start.
  - IDLE: start -> RUN. stop is ignored. clear holds IDLE.
  - RUN: clear -> IDLE with count=0 and prescaler=0. stop -> PAUSE. start holds RUN.
  - PAUSE: clear -> IDLE with zeroing. start (with stop=0) -> RUN. Otherwise hold.
- running is registered and equals (state==RUN).
- Prescaler:
  - Advances only when state==RUN and no clear/stop in that cycle.
  - Counts 0..PRESCALE-1. When it is at PRESCALE-1 on an edge, it wraps to 0 and count increments; tick=1 for the following cycle.
  - PAUSE holds the prescaler value, so a resume continues the partial period.
  - IDLE forces the prescaler to 0.
- Latency:
  - start sampled at edge E0 gives running=1 after E0.
  - The first increment happens at edge E0+PRESCALE, and tick is high in the cycle following that edge.
- BCD arithmetic:
  - d0 increments; when d0==9 it wraps to 0 and carries into d1, and likewise through d3.
  - Digits never leave 0–9.
  - 9999 + 1 wraps to 0000, overflow=1 for one cycle (coincident with tick), and the state remains RUN.
- stop on the same edge as a pending increment: the stop wins, no increment occurs, and the prescaler holds PRESCALE-1. The next resume increments on its first RUN edge.
- clear on the same edge as a pending increment: count=0000, no tick, no overflow.
- Lap capture:
  - lap sampled high in any state latches the pre-edge count (not the incremented value) into lap_val; lap_valid pulses the next cycle.
  - lap held high captures every cycle.
  - lap together with clear captures the pre-clear count.
  - lap_val is unaffected by clear; only reset zeros it.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset then start, PRESCALE=4 → running=1 after the start edge; count=0001 with tick pulse 4 clocks later; count=0005 after 20 RUN clocks.
- Run to count=0009, then one more period → count=0010; from 0099 → 0100; tick pulses exactly once per period.
- Preload by running to 9999 → next period gives count=0000, overflow=1 and tick=1 for one cycle, running stays 1.
- start, run 6 clocks (PRESCALE=4, count=0001, prescaler=2), stop 10 clocks, then start → count holds 0001 while paused; 0002 appears 2 RUN clocks after resume.
- lap at count=0037 while running → lap_val=0037 and lap_valid pulses once; a following clear gives count=0000 with lap_val still 0037.
- start+stop+clear asserted together in RUN → state IDLE, count=0000, running=0; reset mid-RUN → all outputs zero next cycle regardless of commands.

Source files
------------

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch controller: sequences a four-digit BCD count through IDLE / RUN /
// PAUSE, gates increments with a programmable prescaler, and captures lap
// snapshots. Every output is registered. The current FSM state is exposed on
// state_o for observation alongside the functional outputs.
module bcd_stopwatch_ctrl #(
    parameter int PRESCALE = 10,
    parameter int PS_W     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] count,
    output logic [15:0] lap_val,
    output logic        lap_valid,
    output logic        running,
    output logic        tick,
    output logic        overflow,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    state_e          state_q, state_d;
    logic [PS_W-1:0] ps_q, ps_d;
    logic [15:0]     count_q, count_d;
    logic [15:0]     lap_val_q, lap_val_d;
    logic            lap_valid_q, lap_valid_d;
    logic            running_q, running_d;
    logic            tick_q, tick_d;
    logic            overflow_q, overflow_d;
    logic            inc;

    // Add one to a packed four-digit BCD value, rippling the carry upward;
    // 9999 rolls over to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Next-state, prescaler, count and lap logic. clear beats stop beats
    // start; a stop or clear on a pending-increment edge suppresses it.
    always_comb begin
        state_d     = state_q;
        ps_d        = ps_q;
        count_d     = count_q;
        inc         = 1'b0;
        lap_val_d   = lap ? count_q : lap_val_q;
        lap_valid_d = lap;
        if (clear) begin
            state_d = ST_IDLE;
            ps_d    = '0;
            count_d = 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ps_d = '0;
                    if (start && !stop) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_PAUSE;
                    end else if (ps_q == PS_LAST) begin
                        ps_d    = '0;
                        inc     = 1'b1;
                        count_d = bcd_inc(count_q);
                    end else begin
                        ps_d = ps_q + PS_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (start && !stop) state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                    ps_d    = '0;
                end
            endcase
        end
        tick_d     = inc;
        overflow_d = inc && (count_q == 16'h9999);
        running_d  = (state_d == ST_RUN);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ps_q        <= '0;
            count_q     <= 16'h0000;
            lap_val_q   <= 16'h0000;
            lap_valid_q <= 1'b0;
            running_q   <= 1'b0;
            tick_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ps_q        <= ps_d;
            count_q     <= count_d;
            lap_val_q   <= lap_val_d;
            lap_valid_q <= lap_valid_d;
            running_q   <= running_d;
            tick_q      <= tick_d;
            overflow_q  <= overflow_d;
        end
    end

    assign count     = count_q;
    assign lap_val   = lap_val_q;
    assign lap_valid = lap_valid_q;
    assign running   = running_q;
    assign tick      = tick_q;
    assign overflow  = overflow_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: a decimal-integer stopwatch model is advanced
// once per clock with the same commands as the DUT and every output is
// compared after each edge; directed scenarios add literal expectations.
module tb_bcd_stopwatch_ctrl;

    localparam int PRESCALE = 4;
    localparam int MS_IDLE  = 0;
    localparam int MS_RUN   = 1;
    localparam int MS_PAUSE = 2;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, stop, clear, lap;
    logic [15:0] count, lap_val;
    logic        lap_valid, running, tick, overflow;
    logic [1:0]  state_o;

    bcd_stopwatch_ctrl #(.PRESCALE(PRESCALE), .PS_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .lap      (lap),
        .count    (count),
        .lap_val  (lap_val),
        .lap_valid(lap_valid),
        .running  (running),
        .tick     (tick),
        .overflow (overflow),
        .state_o  (state_o)
    );

    // behavioural model: count kept as a plain decimal integer
    int m_state = MS_IDLE;
    int m_ps    = 0;
    int m_cnt   = 0;
    int m_lap   = 0;
    bit m_lapv  = 0;
    bit m_tick  = 0;
    bit m_ovf   = 0;
    bit m_run   = 0;

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit p, input bit c, input bit l);
        bit inc;
        inc = 0;
        if (r) begin
            m_state = MS_IDLE; m_ps = 0; m_cnt = 0; m_lap = 0;
            m_lapv = 0; m_tick = 0; m_ovf = 0; m_run = 0;
            return;
        end
        m_lapv = l;
        if (l) m_lap = m_cnt;
        if (c) begin
            m_state = MS_IDLE; m_cnt = 0; m_ps = 0;
        end else if (m_state == MS_IDLE) begin
            m_ps = 0;
            if (s && !p) m_state = MS_RUN;
        end else if (m_state == MS_RUN) begin
            if (p) m_state = MS_PAUSE;
            else begin
                m_ps = m_ps + 1;
                if (m_ps == PRESCALE) begin
                    m_ps = 0;
                    inc  = 1;
                end
            end
        end else begin
            if (s && !p) m_state = MS_RUN;
        end
        m_tick = inc;
        m_ovf  = inc && (m_cnt == 9999);
        if (inc) m_cnt = (m_cnt + 1) % 10000;
        m_run = (m_state == MS_RUN);
    endtask

    // driver: apply one cycle of commands, advance the model, compare at #1
    task automatic step(input bit r, input bit s, input bit p, input bit c, input bit l);
        @(negedge clk);
        reset = r; start = s; stop = p; clear = c; lap = l;
        @(posedge clk);
        model_edge(r, s, p, c, l);
        #1;
        chk("count",     count,           to_bcd(m_cnt));
        chk("lap_val",   lap_val,         to_bcd(m_lap));
        chk("lap_valid", 16'(lap_valid),  16'(m_lapv));
        chk("running",   16'(running),    16'(m_run));
        chk("tick",      16'(tick),       16'(m_tick));
        chk("overflow",  16'(overflow),   16'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // run until the model reaches a target count (and prescaler phase), bounded
    task automatic run_until(input int target, input int ps, input string name);
        int guard;
        guard = 0;
        while (!(m_cnt == target && (ps < 0 || m_ps == ps)) && guard < 50000) begin
            step(0, 0, 0, 0, 0);
            guard++;
        end
        checks++;
        if (guard >= 50000) begin
            errors++;
            $display("FAIL %s timeout got=%0d exp=%0d", name, m_cnt, target);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;

        // reset state
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        chk("rst_count",   count,         16'h0000);
        chk("rst_running", 16'(running),  16'h0000);
        chk("rst_lapval",  lap_val,       16'h0000);

        // start latency and first increments
        step(0, 1, 0, 0, 0);
        chk("start_running", 16'(running), 16'h0001);
        idle(3);
        chk("pre_first_inc", count, 16'h0000);
        step(0, 0, 0, 0, 0);
        chk("first_inc", count, 16'h0001);
        chk("first_tick", 16'(tick), 16'h0001);
        idle(16);
        chk("after_20", count, 16'h0005);
        idle(20);
        chk("after_40", count, 16'h0010);
        idle(360);
        chk("after_400", count, 16'h0100);

        // wrap 9999 -> 0000
        run_until(9999, PRESCALE - 1, "to_9999");
        chk("pre_wrap", count, 16'h9999);
        step(0, 0, 0, 0, 0);
        chk("wrap_count", count, 16'h0000);
        chk("wrap_ovf",   16'(overflow), 16'h0001);
        chk("wrap_tick",  16'(tick),     16'h0001);
        chk("wrap_run",   16'(running),  16'h0001);
        step(0, 0, 0, 0, 0);
        chk("ovf_pulse", 16'(overflow), 16'h0000);

        // pause / resume keeps the partial period
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        idle(6);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
        chk("paused_count", count, 16'h0001);
        chk("paused_run",   16'(running), 16'h0000);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("resume_1", count, 16'h0001);
        step(0, 0, 0, 0, 0);
        chk("resume_2", count, 16'h0002);

        // stop on a pending-increment edge
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        idle(3);
        step(0, 0, 1, 0, 0);
        chk("stop_pending", count, 16'h0000);
        chk("stop_no_tick", 16'(tick), 16'h0000);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("resume_pending", count, 16'h0001);

        // lap capture then clear
        run_until(37, -1, "to_37");
        step(0, 0, 0, 0, 1);
        chk("lap_val_37", lap_val, 16'h0037);
        chk("lap_valid",  16'(lap_valid), 16'h0001);
        step(0, 0, 0, 0, 0);
        chk("lap_valid_pulse", 16'(lap_valid), 16'h0000);
        step(0, 0, 0, 1, 0);
        chk("clr_count", count,   16'h0000);
        chk("clr_lap",   lap_val, 16'h0037);

        // all commands together in RUN, then reset mid-RUN
        step(0, 1, 0, 0, 0);
        idle(9);
        step(0, 1, 1, 1, 0);
        chk("all_cmd_run",   16'(running), 16'h0000);
        chk("all_cmd_count", count,        16'h0000);
        step(0, 1, 0, 0, 0);
        idle(10);
        step(1, 1, 0, 0, 1);
        chk("rst_mid_count",   count,           16'h0000);
        chk("rst_mid_lap",     lap_val,         16'h0000);
        chk("rst_mid_lapv",    16'(lap_valid),  16'h0000);
        chk("rst_mid_running", 16'(running),    16'h0000);

        // randomized commands against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 31) == 0,
                 $urandom_range(0, 7) == 0);
        end

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
